// File: rtl/baby_bus_pkg.sv
// -----------------------------------------------------------------------------
// baby_bus_pkg
// Shared definitions for the Baby RAM bus controller:
//   - state_t      : controller state encoding
//   - calc_beats   : number of bus beats needed to move one core word
//   - calc_beat_w  : width of the beat index appended to the RAM address
//   - params_ok    : parameter legality check, evaluated at elaboration
// No ports (package).
// -----------------------------------------------------------------------------
package baby_bus_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_TURN_IN,
    ST_ACCESS,
    ST_TURN_OUT,
    ST_ACK
  } state_t;

  function automatic int calc_beats(input int word_w, input int bus_w);
    return word_w / bus_w;
  endfunction

  // A single-beat word needs no beat field in the RAM address.
  function automatic int calc_beat_w(input int beats);
    return (beats > 1) ? $clog2(beats) : 0;
  endfunction

  function automatic bit params_ok(input int word_w, input int bus_w,
                                   input int wait_cyc, input int turn_cyc);
    return (bus_w > 0) && (word_w >= bus_w) && ((word_w % bus_w) == 0) &&
           (wait_cyc >= 0) && (wait_cyc <= 15) &&
           (turn_cyc >= 0) && (turn_cyc <= 7);
  endfunction

endpackage

// File: rtl/baby_bus_pad.sv
// -----------------------------------------------------------------------------
// baby_bus_pad
// BUS_W-wide tristate pad wrapper for the external RAM data bus.
// Ports:
//   pad_io      inout  BUS_W  external bidirectional bus
//   tx_data_i   in     BUS_W  value driven onto the bus
//   drive_en_i  in     1      1 = drive tx_data_i, 0 = release the bus
//   rx_data_o   out    BUS_W  value currently seen on the bus
// -----------------------------------------------------------------------------
module baby_bus_pad #(
  parameter int BUS_W = 8
) (
  inout  wire  [BUS_W-1:0] pad_io,
  input  logic [BUS_W-1:0] tx_data_i,
  input  logic             drive_en_i,
  output logic [BUS_W-1:0] rx_data_o
);

  assign pad_io    = drive_en_i ? tx_data_i : {BUS_W{1'bz}};
  assign rx_data_o = pad_io;

endmodule

// File: rtl/baby_ram_bus_ctrl.sv
// -----------------------------------------------------------------------------
// baby_ram_bus_ctrl
// Sequences one core word access onto an external RAM bus that may be
// narrower than the word, splitting it into BEATS beats (beat 0 = LS slice),
// with WAIT_CYC extra hold cycles per beat and TURN_CYC released cycles
// before the first and after the last write beat.
// Ports:
//   clock         in     single system clock (rising edge)
//   reset_i       in     synchronous active-high reset
//   core_req_i    in     access request, sampled only in IDLE
//   core_we_i     in     1 = write, 0 = read (latched on accept)
//   core_addr_i   in     word address (latched on accept)
//   core_wdata_i  in     write word (latched on accept)
//   core_rdata_o  out    assembled read word, held until the next read ack
//   core_ack_o    out    one-cycle completion pulse
//   busy_o        out    high in every state except IDLE
//   ram_data_io   inout  external data bus
//   ram_addr_o    out    {word address, beat index}
//   ram_rw_en_o   out    1 = write with bus driven, 0 = read / released
// -----------------------------------------------------------------------------
module baby_ram_bus_ctrl
  import baby_bus_pkg::*;
#(
  parameter int  WORD_W   = 32,
  parameter int  BUS_W    = 8,
  parameter int  ADDR_W   = 5,
  parameter int  WAIT_CYC = 1,
  parameter int  TURN_CYC = 1,
  localparam int BEATS    = calc_beats(WORD_W, BUS_W),
  localparam int BEAT_W   = calc_beat_w(BEATS)
) (
  input  logic                     clock,
  input  logic                     reset_i,
  input  logic                     core_req_i,
  input  logic                     core_we_i,
  input  logic [ADDR_W-1:0]        core_addr_i,
  input  logic [WORD_W-1:0]        core_wdata_i,
  output logic [WORD_W-1:0]        core_rdata_o,
  output logic                     core_ack_o,
  output logic                     busy_o,
  inout  wire  [BUS_W-1:0]         ram_data_io,
  output logic [ADDR_W+BEAT_W-1:0] ram_addr_o,
  output logic                     ram_rw_en_o
);

  if (!params_ok(WORD_W, BUS_W, WAIT_CYC, TURN_CYC)) begin : g_bad_params
    $error("baby_ram_bus_ctrl: illegal WORD_W/BUS_W/WAIT_CYC/TURN_CYC");
  end

  // The beat counter keeps at least one bit even for single-beat words.
  localparam int                 BEAT_CW   = (BEAT_W > 0) ? BEAT_W : 1;
  localparam int                 RA_W      = ADDR_W + BEAT_W;
  localparam logic [BEAT_CW-1:0] BEAT_LAST = BEAT_CW'(BEATS - 1);
  localparam logic [3:0]         WAIT_LAST = 4'(WAIT_CYC);
  localparam logic [2:0]         TURN_LAST = 3'((TURN_CYC > 0) ? TURN_CYC - 1 : 0);
  localparam bit                 HAS_TURN  = (TURN_CYC > 0);

  state_t              r_state;
  logic                r_we;
  logic [ADDR_W-1:0]   r_addr;
  logic [WORD_W-1:0]   r_wdata;
  logic [WORD_W-1:0]   r_asm;
  logic [WORD_W-1:0]   r_rdata;
  logic [BEAT_CW-1:0]  r_beat;
  logic [3:0]          r_wait;
  logic [2:0]          r_turn;
  logic                r_ack;
  logic                r_busy;
  logic [RA_W-1:0]     r_ram_addr;
  logic                r_rw;

  logic [BUS_W-1:0]    w_rx;
  logic [BUS_W-1:0]    w_tx;
  logic [WORD_W-1:0]   w_asm_full;

  // {addr, beat} with the beat field dropped when BEAT_W is 0.
  function automatic logic [RA_W-1:0] f_ram_addr(input logic [ADDR_W-1:0]  addr,
                                                 input logic [BEAT_CW-1:0] beat);
    logic [ADDR_W+BEAT_CW-1:0] cat;
    cat = {addr, beat} >> (BEAT_CW - BEAT_W);
    return cat[RA_W-1:0];
  endfunction

  assign w_tx = r_wdata[r_beat*BUS_W +: BUS_W];

  // Final word including the slice sampled on the last beat, so that
  // core_rdata_o changes only once, at the ACK transition.
  always_comb begin
    w_asm_full = r_asm;
    w_asm_full[BEAT_LAST*BUS_W +: BUS_W] = w_rx;
  end

  always_ff @(posedge clock) begin
    if (reset_i) begin
      r_state    <= ST_IDLE;
      r_we       <= 1'b0;
      r_addr     <= '0;
      r_wdata    <= '0;
      r_asm      <= '0;
      r_rdata    <= '0;
      r_beat     <= '0;
      r_wait     <= '0;
      r_turn     <= '0;
      r_ack      <= 1'b0;
      r_busy     <= 1'b0;
      r_ram_addr <= '0;
      r_rw       <= 1'b0;
    end else begin
      r_ack <= 1'b0;
      case (r_state)
        ST_IDLE: begin
          r_ram_addr <= '0;
          r_rw       <= 1'b0;
          r_busy     <= 1'b0;
          if (core_req_i) begin
            r_we       <= core_we_i;
            r_addr     <= core_addr_i;
            r_wdata    <= core_wdata_i;
            r_beat     <= '0;
            r_wait     <= '0;
            r_turn     <= '0;
            r_busy     <= 1'b1;
            r_ram_addr <= f_ram_addr(core_addr_i, '0);
            if (core_we_i && HAS_TURN) begin
              r_state <= ST_TURN_IN;
            end else begin
              r_state <= ST_ACCESS;
              r_rw    <= core_we_i;
            end
          end
        end

        ST_TURN_IN: begin
          if (r_turn == TURN_LAST) begin
            r_turn  <= '0;
            r_state <= ST_ACCESS;
            r_rw    <= 1'b1;
          end else begin
            r_turn <= r_turn + 3'd1;
          end
        end

        ST_ACCESS: begin
          if (r_wait == WAIT_LAST) begin
            r_wait <= '0;
            if (!r_we) begin
              r_asm[r_beat*BUS_W +: BUS_W] <= w_rx;
            end
            if (r_beat == BEAT_LAST) begin
              // Release the bus while the address still points at this word.
              r_rw <= 1'b0;
              if (!r_we) begin
                r_rdata <= w_asm_full;
              end
              if (r_we && HAS_TURN) begin
                r_state <= ST_TURN_OUT;
              end else begin
                r_state <= ST_ACK;
                r_ack   <= 1'b1;
              end
            end else begin
              r_beat     <= r_beat + 1'b1;
              r_ram_addr <= f_ram_addr(r_addr, r_beat + 1'b1);
            end
          end else begin
            r_wait <= r_wait + 4'd1;
          end
        end

        ST_TURN_OUT: begin
          if (r_turn == TURN_LAST) begin
            r_turn  <= '0;
            r_state <= ST_ACK;
            r_ack   <= 1'b1;
          end else begin
            r_turn <= r_turn + 3'd1;
          end
        end

        ST_ACK: begin
          r_state    <= ST_IDLE;
          r_busy     <= 1'b0;
          r_ram_addr <= '0;
        end

        default: begin
          r_state <= ST_IDLE;
          r_busy  <= 1'b0;
          r_rw    <= 1'b0;
        end
      endcase
    end
  end

  baby_bus_pad #(
    .BUS_W (BUS_W)
  ) u_pad (
    .pad_io     (ram_data_io),
    .tx_data_i  (w_tx),
    .drive_en_i (r_rw),
    .rx_data_o  (w_rx)
  );

  assign core_rdata_o = r_rdata;
  assign core_ack_o   = r_ack;
  assign busy_o       = r_busy;
  assign ram_addr_o   = r_ram_addr;
  assign ram_rw_en_o  = r_rw;

endmodule

// File: doc/baby_ram_bus_ctrl.md
Name: baby_ram_bus_ctrl

Overview:
Parametrised successor to the fixed 32-bit, 5-bit-address RAM bus plexer in the Manchester Baby top level. It sequences one core word access onto an external bidirectional RAM bus that may be narrower than the word, splitting the word into beats. It adds programmable wait states and bus turnaround cycles. It sits between the Baby core's RAM port and the chip-level pads and replaces the purely combinational direction mux.

Parameters:
WORD_W, 32, core word width in bits; must be a multiple of BUS_W.
BUS_W, 8, external data bus width in bits.
ADDR_W, 5, core word-address width.
WAIT_CYC, 1, extra hold cycles per beat (0..15).
TURN_CYC, 1, undriven rw=0 cycles before the first and after the last write beat (0..7); 0 removes the TURN state.

Ports:
clock  in  1  single system clock; all logic on the rising edge.
reset_i  in  1  synchronous, active-high reset.
core_req_i  in  1  access request; sampled only in IDLE.
core_we_i  in  1  1 = write, 0 = read; latched on accept.
core_addr_i  in  ADDR_W  word address; latched on accept.
core_wdata_i  in  WORD_W  write word; latched on accept.
core_rdata_o  out  WORD_W  assembled read word; valid when core_ack_o=1.
core_ack_o  out  1  one-cycle completion pulse.
busy_o  out  1  high in every state except IDLE.
ram_data_io  inout  BUS_W  external bidirectional data bus.
ram_addr_o  out  ADDR_W+BEAT_W  {word address, beat index}.
ram_rw_en_o  out  1  0 = read or bus released, 1 = write with bus driven.

Behaviour:
- Derived values: BEATS = WORD_W/BUS_W. BEAT_W = clog2(BEATS) when BEATS>1, else 0 (ram_addr_o is then just the address).
- Reset, synchronous, applied on the next edge:
  - state IDLE.
  - core_ack_o=0, busy_o=0, core_rdata_o=0.
  - ram_addr_o=0, ram_rw_en_o=0, bus undriven.
  - Reset overrides any in-flight access. That access never acks.
- States: IDLE, TURN_IN, ACCESS, TURN_OUT, ACK.
- IDLE:
  - Outputs ram_addr_o=0, ram_rw_en_o=0, bus undriven.
  - If core_req_i=1, latch we, addr and wdata, and set beat=0 and wait counter=0.
  - Then go to TURN_IN if (we and TURN_CYC>0), otherwise to ACCESS.
- TURN_IN: TURN_CYC cycles; ram_addr_o={addr,0}, rw=0, bus undriven; then ACCESS.
- ACCESS:
  - Each beat lasts WAIT_CYC+1 cycles; ram_addr_o={addr,beat}.
  - Write: rw=1, bus driven with wdata[beat*BUS_W +: BUS_W] for the whole beat.
  - Read: rw=0, bus undriven. On the last cycle of the beat, sample ram_data_io into rdata slice [beat*BUS_W +: BUS_W].
  - Beat 0 is the least-significant slice.
  - After the last beat, go to TURN_OUT (write with TURN_CYC>0), otherwise to ACK.
- TURN_OUT: TURN_CYC cycles; ram_addr_o={addr,BEATS-1}, rw=0, bus undriven; then ACK.
- ACK:
  - core_ack_o=1 for exactly one cycle; core_rdata_o holds the assembled word (reads) and keeps it until the next read's ACK.
  - Next state IDLE. No request is accepted in the ACK cycle.
- Latency, with req seen in IDLE at cycle 0:
  - Read ack in cycle 1+BEATS*(WAIT_CYC+1).
  - Write ack in cycle 1+BEATS*(WAIT_CYC+1)+2*TURN_CYC.
- Throughput: with req held high, the next request is accepted in the IDLE cycle right after ACK. No bubble beyond that one cycle.
- Bus discipline: ram_data_io is driven only while ram_rw_en_o=1. A driven-to-released transition never happens in the same cycle that the address changes to a different word.
- Counters: the wait counter wraps to 0 at the end of each beat. The beat counter saturates at BEATS-1 and never wraps into a new word.
- Inputs changing while busy_o=1 are ignored.

Decomposition:
- Shared package baby_bus_pkg:
  - state enum.
  - functions calc_beats(WORD_W, BUS_W) and calc_beat_w(beats).
  - elaboration-time checks that WORD_W % BUS_W == 0 and that WAIT_CYC and TURN_CYC are in range.
- Sub-module baby_bus_pad: a generalised BUS_W tristate pad wrapper with inputs tx_data_i and drive_en_i and output rx_data_o. It is the parametrised form of the existing plexer. The controller holds no tristate logic itself.

Test Plan:
- Reset: drive reset_i for 2 cycles mid-idle -> ack=0, busy=0, rdata=0, ram_addr_o=0, rw=0, bus Z.
- Read, defaults (BUS_W=8, WAIT=1, TURN=1), addr 5, RAM model returns bytes EF,BE,AD,DE -> ram_addr_o=20,21,22,23 for 2 cycles each (cycles 1-8), rw=0 throughout, ack in cycle 9, rdata=0xDEADBEEF.
- Write, addr 31, data 0x12345678:
  - cycle 1 TURN_IN (addr 124, bus Z).
  - cycles 2-9 drive 78,56,34,12 at addrs 124-127 with rw=1.
  - cycle 10 TURN_OUT (addr 127, bus Z).
  - ack in cycle 11.
- Back-to-back: req held high for read then write -> second accepted in cycle 10, its ack in cycle 21, exactly one IDLE cycle between.
- Reset mid-write: reset_i=1 in cycle 5 -> cycle 6 rw=0, bus Z, busy=0, no ack; a subsequent read completes normally.
- Corner config (BUS_W=32, WAIT=0, TURN=0), read addr 3 with bus=0xCAFEF00D -> ram_addr_o=3 in cycle 1, ack in cycle 2, rdata=0xCAFEF00D; a write has no TURN cycles and acks in cycle 2.
